// File: rtl/mdu_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package mdu_pkg;

   localparam int unsigned MDU_W            = 32;
   localparam int unsigned CNT_W            = 4;
   localparam int unsigned DEF_MULT_CYCLES  = 5;
   localparam int unsigned DEF_DIV_CYCLES   = 10;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // True for the ops that occupy the unit for multiple cycles.
   function automatic logic is_long_op(input md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath: returns {hi, lo} for mult/multu/div/divu.
// Divide by zero yields {a, 32'hFFFFFFFF}; the controller decides whether it is committed.
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [MDU_W-1:0]   a,
   input  logic [MDU_W-1:0]   b,
   input  md_op_e             op,
   output logic [2*MDU_W-1:0] res_c
);

   logic                 sgn;
   logic [MDU_W-1:0]     dvd;
   logic [MDU_W-1:0]     dvs;
   logic [MDU_W-1:0]     uq;
   logic [MDU_W-1:0]     ur;
   logic [MDU_W-1:0]     q;
   logic [MDU_W-1:0]     r;
   logic [2*MDU_W-1:0]   a_sx;
   logic [2*MDU_W-1:0]   b_sx;
   logic [2*MDU_W-1:0]   a_zx;
   logic [2*MDU_W-1:0]   b_zx;

   always_comb begin
      sgn  = (op == MD_DIV);
      a_sx = {{MDU_W{a[MDU_W-1]}}, a};
      b_sx = {{MDU_W{b[MDU_W-1]}}, b};
      a_zx = {{MDU_W{1'b0}}, a};
      b_zx = {{MDU_W{1'b0}}, b};

      // Signed divide runs on magnitudes; 0x80000000 negates to itself, which is what we want.
      dvd  = (sgn && a[MDU_W-1]) ? MDU_W'(~a + MDU_W'(1)) : a;
      dvs  = (sgn && b[MDU_W-1]) ? MDU_W'(~b + MDU_W'(1)) : b;
      uq   = (dvs == '0) ? '0 : dvd / dvs;
      ur   = (dvs == '0) ? '0 : dvd % dvs;
      q    = (sgn && (a[MDU_W-1] ^ b[MDU_W-1])) ? MDU_W'(~uq + MDU_W'(1)) : uq;
      r    = (sgn && a[MDU_W-1]) ? MDU_W'(~ur + MDU_W'(1)) : ur;

      res_c = '0;
      case (op)
         MD_MULT:  res_c = a_sx * b_sx;
         MD_MULTU: res_c = a_zx * b_zx;
         MD_DIV,
         MD_DIVU:  res_c = (b == '0) ? {a, {MDU_W{1'b1}}} : {r, q};
         default:  res_c = '0;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: HI/LO registers, fixed-latency busy counter, D-stage stall.
// Optional MDU_DIVZERO_HOLD_EN: divide by zero becomes a no-op with no busy cycles.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       MDOp,
   input  logic [MDU_W-1:0] A,
   input  logic [MDU_W-1:0] B,
   input  logic             D_IsMD,
   output logic             Busy,
   output logic [MDU_W-1:0] HI,
   output logic [MDU_W-1:0] LO,
   output logic             Stall
);

   mdu_state_e          state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic [MDU_W-1:0]    hi_q, hi_d;
   logic [MDU_W-1:0]    lo_q, lo_d;
   logic [MDU_W-1:0]    pend_hi_q, pend_hi_d;
   logic [MDU_W-1:0]    pend_lo_q, pend_lo_d;

   md_op_e              op;
   logic                start_long;
   logic                div_zero_skip;
   logic [2*MDU_W-1:0]  res_c;

   assign op         = md_op_e'(MDOp);
   assign start_long = Start && is_long_op(op);

`ifdef MDU_DIVZERO_HOLD_EN
   assign div_zero_skip = ((op == MD_DIV) || (op == MD_DIVU)) && (B == '0);
`else
   assign div_zero_skip = 1'b0;
`endif

   mdu_calc u_calc (
      .a     (A),
      .b     (B),
      .op    (op),
      .res_c (res_c)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     if (!div_zero_skip) begin
                        pend_hi_d = res_c[2*MDU_W-1:MDU_W];
                        pend_lo_d = res_c[MDU_W-1:0];
                        cnt_d     = ((op == MD_MULT) || (op == MD_MULTU)) ?
                                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        busy_d    = 1'b1;
                        state_d   = ST_RUN;
                     end
                  end
                  MD_MTHI: hi_d = A;
                  MD_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            // Commit on the last busy edge so HI/LO are valid when Busy first reads 0.
            if (cnt_q == CNT_W'(1)) begin
               hi_d    = pend_hi_q;
               lo_d    = pend_lo_q;
               busy_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
      end
   end

   assign Busy  = busy_q;
   assign HI    = hi_q;
   assign LO    = lo_q;
   assign Stall = D_IsMD && (busy_q || start_long);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed vector table, corner sequences, random ops vs. model.
module tb_mdu_ctrl;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   typedef longint unsigned u64_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        ismd;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_cyc;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Start = 1'b0;
   logic [2:0]  MDOp = 3'd0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        D_IsMD = 1'b0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Stall;

   int errors = 0;
   int checks = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .Start  (Start),
      .MDOp   (MDOp),
      .A      (A),
      .B      (B),
      .D_IsMD (D_IsMD),
      .Busy   (Busy),
      .HI     (HI),
      .LO     (LO),
      .Stall  (Stall)
   );

   always #5 Clock = ~Clock;

   // The hazard unit must never issue a new MD op while the unit is busy.
   always @(posedge Clock) begin
      if (!Reset && Busy && Start && (MDOp >= 3'd1) && (MDOp <= 3'd6)) begin
         errors++;
         $display("FAIL start_in_run: Start=1 op=%0d while Busy=1", MDOp);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Architectural reference: the HI/LO result and the busy length of one MD op.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo, output int cyc);
      longint p;
      u64_t   pu;
      cyc = 0;
      case (op)
         3'd1: begin
            p = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32]; lo = p[31:0]; cyc = MC;
         end
         3'd2: begin
            pu = u64_t'(a) * u64_t'(b);
            hi = pu[63:32]; lo = pu[31:0]; cyc = MC;
         end
         3'd3, 3'd4: begin
            if (b == 0) begin
`ifndef MDU_DIVZERO_HOLD_EN
               hi = a; lo = 32'hFFFF_FFFF; cyc = DC;
`endif
            end else if (op == 3'd3) begin
               p  = longint'($signed(a)) / longint'($signed(b));
               lo = p[31:0];
               p  = longint'($signed(a)) % longint'($signed(b));
               hi = p[31:0];
               cyc = DC;
            end else begin
               lo = a / b; hi = a % b; cyc = DC;
            end
         end
         3'd5: hi = a;
         3'd6: lo = a;
         default: ;
      endcase
   endfunction

   // Issue one op at a negedge, then count busy cycles with Stall checked throughout.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic ismd, output int cyc);
      logic long_op;
      long_op = (op >= 3'd1) && (op <= 3'd4);
      @(negedge Clock);
      Start = 1'b1; MDOp = op; A = a; B = b; D_IsMD = ismd;
      #1;
      check("stall_issue", 32'(Stall), 32'(ismd & long_op));
      @(negedge Clock);
      Start = 1'b0; MDOp = 3'd0;
      cyc = 0;
      while (Busy && cyc < 40) begin
         check("stall_busy", 32'(Stall), 32'(ismd));
         cyc++;
         @(negedge Clock);
      end
      check("stall_done", 32'(Stall), 32'd0);
      D_IsMD = 1'b0;
   endtask

   vec_t vecs[$];

   initial begin
      int cyc;
      int exp_cyc;

      vecs.push_back('{3'd1, 32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
      vecs.push_back('{3'd2, 32'hFFFFFFFD, 32'd5,        1'b0, 32'h00000004, 32'hFFFFFFF1, 5});
      vecs.push_back('{3'd3, 32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      vecs.push_back('{3'd4, 32'd7,        32'd2,        1'b0, 32'd1,        32'd3,        10});
      vecs.push_back('{3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 10});
      vecs.push_back('{3'd3, 32'd7,        32'hFFFFFFFE, 1'b1, 32'd1,        32'hFFFFFFFD, 10});
      vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 5});
      vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000, 5});
      vecs.push_back('{3'd4, 32'hFFFFFFFF, 32'd10,       1'b0, 32'd5,        32'h19999999, 10});
      vecs.push_back('{3'd0, 32'hDEADBEEF, 32'd3,        1'b1, 32'd5,        32'h19999999, 0});
      vecs.push_back('{3'd7, 32'hCAFEF00D, 32'd9,        1'b1, 32'd5,        32'h19999999, 0});

      // Reset state.
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_stall", 32'(Stall), 32'd0);

      // Directed table.
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ismd, cyc);
         check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         check($sformatf("vec%0d_hi", i), HI, vecs[i].exp_hi);
         check($sformatf("vec%0d_lo", i), LO, vecs[i].exp_lo);
      end
      m_hi = 32'd5; m_lo = 32'h19999999;

      // Back-to-back MTHI/MTLO with an MD instruction in D.
      @(negedge Clock);
      Start = 1'b1; MDOp = 3'd5; A = 32'h12345678; D_IsMD = 1'b1;
      #1 check("mthi_stall", 32'(Stall), 32'd0);
      @(negedge Clock);
      check("mthi_hi", HI, 32'h12345678);
      check("mthi_busy", 32'(Busy), 32'd0);
      MDOp = 3'd6; A = 32'h9;
      #1 check("mtlo_stall", 32'(Stall), 32'd0);
      @(negedge Clock);
      Start = 1'b0; MDOp = 3'd0; D_IsMD = 1'b0;
      check("mtlo_lo", LO, 32'h9);
      check("mtlo_hi", HI, 32'h12345678);
      check("mtlo_busy", 32'(Busy), 32'd0);
      m_hi = 32'h12345678; m_lo = 32'h9;

      // Divide by zero, signed and unsigned.
      for (int k = 0; k < 2; k++) begin
         logic [2:0] dop;
         dop = (k == 0) ? 3'd3 : 3'd4;
         model(dop, 32'h55 + 32'(k), 32'd0, m_hi, m_lo, exp_cyc);
         run_op(dop, 32'h55 + 32'(k), 32'd0, 1'b1, cyc);
         check($sformatf("divz%0d_cycles", k), 32'(cyc), 32'(exp_cyc));
         check($sformatf("divz%0d_hi", k), HI, m_hi);
         check($sformatf("divz%0d_lo", k), LO, m_lo);
      end

      // Reset held two cycles mid-operation: pending result is dropped.
      @(negedge Clock);
      Start = 1'b1; MDOp = 3'd1; A = 32'd3; B = 32'd7;
      @(negedge Clock);
      Start = 1'b0; MDOp = 3'd0;
      @(negedge Clock);
      check("mid_busy", 32'(Busy), 32'd1);
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      check("mrst_busy", 32'(Busy), 32'd0);
      check("mrst_hi", HI, 32'd0);
      check("mrst_lo", LO, 32'd0);
      repeat (8) @(negedge Clock);
      check("mrst_late_busy", 32'(Busy), 32'd0);
      check("mrst_late_lo", LO, 32'd0);
      m_hi = '0; m_lo = '0;

      // Random ops against the reference model.
      for (int n = 0; n < 60; n++) begin
         logic [2:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         logic        rmd;
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         rmd = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0: rb = 32'd0;
            1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            2: rb = 32'($urandom_range(1, 20));
            default: ;
         endcase
         model(rop, ra, rb, m_hi, m_lo, exp_cyc);
         run_op(rop, ra, rb, rmd, cyc);
         check($sformatf("rnd%0d_op%0d_cycles", n, rop), 32'(cyc), 32'(exp_cyc));
         check($sformatf("rnd%0d_op%0d_hi", n, rop), HI, m_hi);
         check($sformatf("rnd%0d_op%0d_lo", n, rop), LO, m_lo);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide sequencer for the E stage of the 5-stage pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E, holds the HI/LO architectural registers and models fixed multi-cycle latency with a busy counter.
- Drives a stall request that the hazard unit ORs into its Stop, so D-stage MD instructions (including mfhi/mflo) wait while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high.
- Start  input  1  E-stage instruction is an MD op; qualifies MDOp.
- MDOp  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- A  input  32  forwarded rs value (ALU_A).
- B  input  32  forwarded rt value (ALU_B, never the immediate).
- D_IsMD  input  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- Busy  output  1  operation in flight; registered.
- HI  output  32  HI register; registered.
- LO  output  32  LO register; registered.
- Stall  output  1  combinational: D_IsMD & (Busy | (Start & MDOp in 1..4)).

Behaviour:
- Clock and reset: single clock Clock. Reset is synchronous and active-high, named Reset.
- Reset values: state IDLE, counter 0, Busy 0, HI 0, LO 0. Reset mid-operation abandons the pending result.
- FSM states are IDLE and RUN. The counter is 4 bits. The pending result is held in two 32-bit shadow registers, pend_hi and pend_lo.
- IDLE, Start & MDOp in 1..4 at edge t:
  - Compute the result from A and B sampled at edge t and load it into the shadow registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
  - Busy is high for cycles t+1 .. t+N.
- RUN: the counter decrements each edge.
  - At the edge where the counter equals 1: HI <= pend_hi, LO <= pend_lo, Busy <= 0, go to IDLE.
  - Net effect: new HI/LO are visible in the same cycle Busy first reads 0.
- IDLE, Start & MDOp = MTHI or MTLO: HI <= A (or LO <= A) at that edge. No busy cycles.
- Start while in RUN is ignored and HI/LO are unaffected. The hazard unit guarantees this cannot happen; the bench flags it as an assertion.
- Start & MDOp = NONE or 7: no effect.
- Arithmetic:
  - MULT is signed 32x32->64; MULTU is unsigned. HI = upper 32 bits, LO = lower 32 bits.
  - DIV is signed, truncating toward zero: LO = quotient, HI = remainder, with the remainder taking the dividend's sign. DIVU is unsigned.
  - Signed overflow case 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
- mfhi/mflo read HI/LO directly in E. They are only reached when Busy = 0 and no MD Start is pending, because Stall holds them in D.
- Stall is asserted for the Start cycle itself, so a back-to-back MD pair stalls with no gap.

Optional Feature:
- Macro: MDU_DIVZERO_HOLD_EN.
- Defined: div/divu with B = 0 takes no busy cycles, leaves HI/LO unchanged, and Busy stays 0.
- Undefined: B = 0 runs the full DIV_CYCLES, then writes HI = A and LO = 32'hFFFFFFFF (both signed and unsigned).

Decomposition:
- Shared package mdu_pkg:
  - MDOp encodings: MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - Default cycle counts.
  - FSM state encodings: ST_IDLE, ST_RUN.
- The ctrl decoder imports the MDOp encodings when generating MDOp_E and D_IsMD.
- One sub-module, mdu_calc: purely combinational. Takes A, B and op; returns 64-bit {hi, lo}, covering the signed/unsigned and divide-by-zero rules. mdu_ctrl owns only sequencing and state.

Test Plan:
- Reset sequence: hold Reset 2 cycles mid-RUN, then release -> Busy=0, HI=0, LO=0; the pending result is never committed.
- MULT A=32'hFFFFFFFD (-3), B=5 -> Busy high for exactly 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. MULTU with the same operands -> HI=32'h00000004, LO=32'hFFFFFFF1.
- DIV A=32'hFFFFFFF9 (-7), B=2 -> 10 busy cycles, LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
- MTHI A=32'h12345678 then MTLO A=32'h9 on consecutive cycles -> HI and LO update on each edge, Busy never asserts, Stall stays 0.
- MULT issued with D_IsMD=1 (mflo in D) -> Stall=1 in the Start cycle and all 5 busy cycles; in the first cycle with Busy=0, Stall=0 and LO already holds the product.
- DIV B=0, run twice (once with MDU_DIVZERO_HOLD_EN defined, once undefined) -> defined: HI/LO unchanged, Busy=0. Undefined: 10 busy cycles, then HI=A, LO=32'hFFFFFFFF.
